// File: rtl/sha256_msg_feeder.sv
// Word server for sha256_stream: holds the 80-byte block header and a nonce
// counter, and synthesises padded 512-bit chunks one word per request.
module sha256_msg_feeder #(
    parameter bit          NONCE_SWAP = 1'b1,
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hdr_we,
    input  logic [4:0]   hdr_addr,
    input  logic [31:0]  hdr_data,
    input  logic         nonce_we,
    input  logic         nonce_inc,
    output logic [31:0]  nonce,
    output logic         nonce_wrap,
    input  logic [1:0]   sel,
    input  logic [255:0] digest_in,
    input  logic         rq,
    input  logic [3:0]   addr,
    output logic         rdy,
    output logic [31:0]  data
);

    localparam int unsigned HdrWords = 20;

    logic [31:0]  hdr_q [HdrWords];
    logic [31:0]  nonce_q;
    logic         nonce_wrap_q;
    logic         rdy_q;
    logic [31:0]  data_q;

    logic [32:0]  nonce_sum;
    logic [31:0]  nonce_word;
    logic [255:0] digest_sh;
    logic [31:0]  word;

    assign nonce      = nonce_q;
    assign nonce_wrap = nonce_wrap_q;
    assign rdy        = rdy_q;
    assign data       = data_q;

    assign nonce_sum = {1'b0, nonce_q} + {1'b0, NONCE_STEP};

    // Combinational word generator: chunk contents from header, nonce and digest.
    always_comb begin
        nonce_word = NONCE_SWAP ? {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]}
                                : nonce_q;
        // Bring digest word H[addr] to the top 32 bits.
        digest_sh  = digest_in << {addr[2:0], 5'd0};
        word       = 32'h0;
        case (sel)
            2'd0: word = hdr_q[{1'b0, addr}];
            2'd1: begin
                // Header words 16..18, nonce in place of word 19, then padding
                // for a 640-bit message.
                if (addr < 4'd3) begin
                    word = hdr_q[5'd16 + {3'd0, addr[1:0]}];
                end else if (addr == 4'd3) begin
                    word = nonce_word;
                end else if (addr == 4'd4) begin
                    word = 32'h8000_0000;
                end else if (addr == 4'd15) begin
                    word = 32'h0000_0280;
                end
            end
            2'd2: begin
                // 256-bit digest followed by padding for a 256-bit message.
                if (!addr[3]) begin
                    word = digest_sh[255:224];
                end else if (addr == 4'd8) begin
                    word = 32'h8000_0000;
                end else if (addr == 4'd15) begin
                    word = 32'h0000_0100;
                end
            end
            default: word = 32'h0;
        endcase
    end

    // Header store; index 19 is kept but never served (the nonce takes its slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HdrWords; i++) begin
                hdr_q[i] <= 32'h0;
            end
        end else if (hdr_we && (hdr_addr < 5'(HdrWords))) begin
            hdr_q[hdr_addr] <= hdr_data;
        end
    end

    // Nonce counter: load beats increment; wrap flags a carry out of bit 31.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q      <= 32'h0;
            nonce_wrap_q <= 1'b0;
        end else if (nonce_we) begin
            nonce_q      <= hdr_data;
            nonce_wrap_q <= 1'b0;
        end else if (nonce_inc) begin
            nonce_q      <= nonce_sum[31:0];
            nonce_wrap_q <= nonce_sum[32];
        end else begin
            nonce_wrap_q <= 1'b0;
        end
    end

    // Fetch handshake: capture on rq while idle, rdy is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            data_q <= 32'h0;
        end else if (rdy_q) begin
            rdy_q  <= 1'b0;
        end else if (rq) begin
            rdy_q  <= 1'b1;
            data_q <= word;
        end
    end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Self-checking bench for sha256_msg_feeder: directed plan plus random traffic,
// with a chunk-level reference model and a scoreboard-driven monitor.
module tb_sha256_msg_feeder;

    localparam bit          NONCE_SWAP = 1'b1;
    localparam logic [31:0] NONCE_STEP = 32'd1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hdr_we;
    logic [4:0]   hdr_addr;
    logic [31:0]  hdr_data;
    logic         nonce_we;
    logic         nonce_inc;
    logic [31:0]  nonce;
    logic         nonce_wrap;
    logic [1:0]   sel;
    logic [255:0] digest_in;
    logic         rq;
    logic [3:0]   addr;
    logic         rdy;
    logic [31:0]  data;

    sha256_msg_feeder #(
        .NONCE_SWAP(NONCE_SWAP),
        .NONCE_STEP(NONCE_STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hdr_we    (hdr_we),
        .hdr_addr  (hdr_addr),
        .hdr_data  (hdr_data),
        .nonce_we  (nonce_we),
        .nonce_inc (nonce_inc),
        .nonce     (nonce),
        .nonce_wrap(nonce_wrap),
        .sel       (sel),
        .digest_in (digest_in),
        .rq        (rq),
        .addr      (addr),
        .rdy       (rdy),
        .data      (data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [31:0] m_hdr [20];
    logic [31:0] m_nonce;
    logic        m_wrap;
    logic        exp_rdy;
    logic [31:0] sb [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Chunk built from the message layout: 80-byte header with the nonce as
    // its last word, or a 32-byte digest, each followed by standard padding.
    function automatic logic [31:0] model_word(logic [1:0] s, logic [3:0] a);
        logic [31:0] ch [16];
        logic [31:0] ser;
        for (int i = 0; i < 16; i++) ch[i] = 32'h0;
        if (NONCE_SWAP) ser = {<<8{m_nonce}};
        else            ser = m_nonce;
        case (s)
            2'd0: for (int i = 0; i < 16; i++) ch[i] = m_hdr[i];
            2'd1: begin
                for (int i = 0; i < 3; i++) ch[i] = m_hdr[16+i];
                ch[3]  = ser;
                ch[4]  = 32'h8000_0000;
                ch[15] = 32'(80 * 8);
            end
            2'd2: begin
                for (int i = 0; i < 8; i++) ch[i] = digest_in[255-32*i -: 32];
                ch[8]  = 32'h8000_0000;
                ch[15] = 32'(32 * 8);
            end
            default: ;
        endcase
        return ch[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 20; i++) m_hdr[i] = 32'h0;
        m_nonce = 32'h0;
        m_wrap  = 1'b0;
        exp_rdy = 1'b0;
        sb.delete();
    endtask

    // One clock: predict from pre-edge state, advance model after the edge.
    task automatic step();
        logic [32:0] s;
        if (rst_n && rq && !exp_rdy) sb.push_back(model_word(sel, addr));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (hdr_we && hdr_addr < 5'd20) m_hdr[hdr_addr] = hdr_data;
            if (nonce_we) begin
                m_nonce = hdr_data;
                m_wrap  = 1'b0;
            end else if (nonce_inc) begin
                s       = {1'b0, m_nonce} + {1'b0, NONCE_STEP};
                m_nonce = s[31:0];
                m_wrap  = s[32];
            end else begin
                m_wrap = 1'b0;
            end
            exp_rdy = exp_rdy ? 1'b0 : rq;
        end
        @(negedge clk);
    endtask

    task automatic fetch(input logic [1:0] s, input logic [3:0] a);
        sel  = s;
        addr = a;
        rq   = 1'b1;
        step();
        rq   = 1'b0;
        step();
    endtask

    // Monitor: checks outputs against the model and pops the scoreboard on rdy.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_rdy", 32'(rdy), 32'h0);
            check("reset_data", data, 32'h0);
            check("reset_nonce", nonce, 32'h0);
        end else begin
            check("rdy", 32'(rdy), 32'(exp_rdy));
            check("nonce", nonce, m_nonce);
            check("nonce_wrap", 32'(nonce_wrap), 32'(m_wrap));
            if (rdy) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rdy actual=1 required=0 at %0t", $time);
                end else begin
                    check("data", data, sb.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        rst_n = 1'b0; hdr_we = 1'b0; hdr_addr = '0; hdr_data = '0;
        nonce_we = 1'b0; nonce_inc = 1'b0; sel = 2'd0; digest_in = '0;
        rq = 1'b1; addr = 4'd0;
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        rq = 1'b0;
        step();

        // Header load, including an ignored out-of-range write.
        hdr_we = 1'b1;
        for (int i = 0; i < 20; i++) begin
            hdr_addr = 5'(i);
            hdr_data = 32'h1000 + 32'(i);
            step();
        end
        hdr_addr = 5'd21;
        hdr_data = 32'hDEAD_BEEF;
        step();
        hdr_we = 1'b0;
        for (int i = 0; i < 16; i++) fetch(2'd0, 4'(i));

        hdr_data = 32'h1234_5678;
        nonce_we = 1'b1;
        step();
        nonce_we = 1'b0;
        for (int i = 0; i < 16; i++) fetch(2'd1, 4'(i));

        for (int i = 0; i < 8; i++) digest_in[255-32*i -: 32] = 32'hA0 + 32'(i);
        for (int i = 0; i < 16; i++) fetch(2'd2, 4'(i));
        fetch(2'd3, 4'd7);

        // Wrap, then load-over-increment priority.
        hdr_data = 32'hFFFF_FFFF;
        nonce_we = 1'b1;
        step();
        nonce_we  = 1'b0;
        nonce_inc = 1'b1;
        step();
        nonce_inc = 1'b0;
        step();
        hdr_data  = 32'h5;
        nonce_we  = 1'b1;
        nonce_inc = 1'b1;
        step();
        nonce_we  = 1'b0;
        nonce_inc = 1'b0;
        step();

        // Same-edge nonce load and fetch of the nonce word returns the old value.
        hdr_data = 32'hCAFE_0001;
        nonce_we = 1'b1;
        sel = 2'd1; addr = 4'd3; rq = 1'b1;
        step();
        nonce_we = 1'b0; rq = 1'b0;
        step();

        // Continuous rq: rdy every second cycle, then reset while rdy is high.
        sel = 2'd0;
        addr = 4'd2;
        rq = 1'b1;
        repeat (6) step();
        if (!exp_rdy) step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_rdy", 32'(rdy), 32'h0);
        check("async_reset_data", data, 32'h0);
        model_reset();
        @(negedge clk);
        step();
        rq = 1'b0;
        rst_n = 1'b1;
        step();
        fetch(2'd0, 4'd3);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            hdr_we    = ($urandom_range(0, 3) == 0);
            hdr_addr  = 5'($urandom_range(0, 23));
            nonce_we  = ($urandom_range(0, 7) == 0);
            nonce_inc = ($urandom_range(0, 2) == 0);
            hdr_data  = nonce_we ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            rq        = $urandom_range(0, 1) == 1;
            sel       = 2'($urandom_range(0, 3));
            addr      = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < 8; i++) digest_in[255-32*i -: 32] = $urandom;
            end
            step();
        end
        hdr_we = 1'b0; nonce_we = 1'b0; nonce_inc = 1'b0; rq = 1'b0;
        repeat (3) step();
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
